mem_read_streamer: RTL and testbench

//  Read-side address generator and stream source for one port of the asymmetric dual-port RAM.
//  - On a start pulse, issues LEN sequential word reads from a byte-space start address.
//  - Absorbs the RAM's 1-cycle read latency and emits words as a valid/ready stream with last flag.
//  - Sits directly downstream of the RAM read port; its consumer (FU input / DMA) may stall at any time.

---
 rtl/mem_read_streamer.sv | 164 ++++++++++++++++
 tb/tb_mem_read_streamer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_streamer.sv
// Read-side address generator and stream source for one RAM read port.
// Issues sequential word reads, absorbs the 1-cycle RAM latency, and emits a valid/ready stream.
module mem_read_streamer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_length,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_mem_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_m_valid,
  output logic [DATA_W-1:0] o_m_data,
  output logic              o_m_last,
  input  logic              i_m_ready,
  output logic [1:0]        o_state
);

  localparam int BYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_issue_left;
  logic               r_inflight;
  logic               r_inflight_last;

  logic [DATA_W-1:0]  r_fifo_data [2];
  logic               r_fifo_last [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;

  logic [2:0]         w_outstanding;
  logic               w_mem_en;
  logic               w_issue_last;
  logic               w_head_fifo;
  logic               w_m_valid;
  logic [DATA_W-1:0]  w_m_data;
  logic               w_m_last;
  logic               w_pop;
  logic               w_pop_fifo;
  logic               w_push;

  // Credit: words buffered plus the read still in the RAM pipe never exceed two.
  assign w_outstanding = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_mem_en      = (r_state == S_RUN) && (w_outstanding < 3'd2);
  assign w_issue_last  = w_mem_en && (r_issue_left == LEN_W'(1));

  // Stream: a beat transfers on any cycle with o_m_valid && i_m_ready; while stalled,
  // o_m_data/o_m_last hold. An empty FIFO forwards the returning RAM word directly.
  assign w_head_fifo = (r_count != 2'd0);
  assign w_m_valid   = w_head_fifo || r_inflight;

  always_comb begin
    w_m_data = '0;
    w_m_last = 1'b0;
    if (w_head_fifo) begin
      w_m_data = r_fifo_data[r_rd_ptr];
      w_m_last = r_fifo_last[r_rd_ptr];
    end else if (r_inflight) begin
      w_m_data = i_mem_rdata;
      w_m_last = r_inflight_last;
    end
  end

  assign w_pop      = w_m_valid && i_m_ready;
  assign w_pop_fifo = w_pop && w_head_fifo;
  assign w_push     = r_inflight && !(w_pop && !w_head_fifo);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_issue_left    <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_mem_en;
      r_inflight_last <= w_issue_last;
      unique case (r_state)
        S_IDLE: begin
          if (i_run) begin
            if (i_length == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state      <= S_RUN;
              r_addr       <= i_start_addr & ALIGN_MASK;
              r_issue_left <= i_length;
            end
          end
        end
        S_RUN: begin
          if (w_mem_en) begin
            r_addr       <= r_addr + ADDR_STEP;
            r_issue_left <= r_issue_left - LEN_W'(1);
            if (w_issue_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && w_m_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_last[i] <= 1'b0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= i_mem_rdata;
        r_fifo_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop_fifo) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop_fifo})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done     = (r_state == S_DONE);
  assign o_mem_en   = w_mem_en;
  assign o_mem_addr = r_addr;
  assign o_m_valid  = w_m_valid;
  assign o_m_data   = w_m_data;
  assign o_m_last   = w_m_last;
  assign o_state    = r_state;

endmodule

// File: tb/tb_mem_read_streamer.sv
// Bench for mem_read_streamer: RAM model, directed timing steps and randomized transfers,
// with a monitor checking every read address and beat against a transfer-level expectation.
module tb_mem_read_streamer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 6;
  localparam int LEN_W   = 6;
  localparam int BYTES   = DATA_W / 8;
  localparam int WORD_SH = $clog2(BYTES);
  localparam int WORDS   = (1 << ADDR_W) / BYTES;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;
  logic [1:0]        state;

  logic [DATA_W-1:0] ram [WORDS];
  logic [DATA_W-1:0] exp_q[$];
  logic              exp_last_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;
  int   n_popped = 0;
  logic armed    = 1'b0;
  int   ready_mode = 0;
  int   pat_idx    = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  mem_read_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_start_addr(start_addr), .i_length(length),
    .o_busy(busy), .o_done(done), .o_mem_en(mem_en), .o_mem_addr(mem_addr),
    .i_mem_rdata(mem_rdata), .o_m_valid(m_valid), .o_m_data(m_data), .o_m_last(m_last),
    .i_m_ready(m_ready), .o_state(state)
  );

  // Clock and RAM model: read data appears the cycle after the enable, garbage otherwise.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) mem_rdata <= ram[mem_addr[ADDR_W-1:WORD_SH]];
    else        mem_rdata <= $urandom;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: addresses in order, credit limit, beat data/last, stability under stall.
  always @(negedge clk) begin
    if (!rst) begin
      int n_out;
      n_out = n_issued - n_popped;
      if (armed) check("mem_en_credit", mem_en, (exp_addr_q.size() > 0) && (n_out < 2));
      if (mem_en) begin
        check("read_expected", exp_addr_q.size() > 0, 1);
        if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
        n_issued++;
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("m_data", m_data, exp_q.pop_front());
          check("m_last", m_last, exp_last_q.pop_front());
        end
        n_popped++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_ready();
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin
        m_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  // Called at the start of cycle 0; returns at the start of cycle 1.
  task automatic start_xfer(input logic [ADDR_W-1:0] a, input int len);
    logic [ADDR_W-1:0] base;
    base = a & ~ADDR_W'(BYTES - 1);
    for (int k = 0; k < len; k++) begin
      logic [ADDR_W-1:0] wa;
      wa = base + ADDR_W'(k * BYTES);
      exp_addr_q.push_back(wa);
      exp_q.push_back(ram[wa[ADDR_W-1:WORD_SH]]);
      exp_last_q.push_back(k == len - 1);
    end
    armed      = 1'b0;
    run        = 1'b1;
    start_addr = a;
    length     = LEN_W'(len);
    next_cycle();
    run   = 1'b0;
    armed = 1'b1;
  endtask

  task automatic flush();
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    n_issued = 0;
    n_popped = 0;
    armed    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
      else next_cycle();
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_beats_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, exp_addr_q.size(), 0);
    flush();
    next_cycle();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_last"}, m_last, 0);
    check({tag, "_m_data"}, m_data, 0);
  endtask

  initial begin
    int pop_base;
    bit got;
    for (int i = 0; i < WORDS; i++) ram[i] = $urandom;
    rst = 1'b1; run = 1'b0; start_addr = '0; length = '0; m_ready = 1'b0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    reset_checks("reset");
    next_cycle();
    rst = 1'b0;

    // Basic timing: length 4 at 0x10 with the consumer always ready
    ready_mode = 0;
    next_cycle();
    start_xfer(6'h10, 4);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) next_cycle();
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", c), busy, (c <= 5));
      check($sformatf("t1_mem_en_c%0d", c), mem_en, (c <= 4));
      if (c <= 4) check($sformatf("t1_addr_c%0d", c), mem_addr, 6'h10 + 6'(4 * (c - 1)));
      check($sformatf("t1_valid_c%0d", c), m_valid, (c >= 2) && (c <= 5));
      check($sformatf("t1_last_c%0d", c), m_last, (c == 5));
      check($sformatf("t1_done_c%0d", c), done, (c == 6));
    end
    check("t1_beats_left", exp_q.size(), 0);
    flush();
    next_cycle();

    // Zero length: done one cycle after run, nothing else moves
    start_xfer(6'h08, 0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) next_cycle();
      @(negedge clk);
      check($sformatf("t2_done_c%0d", c), done, (c == 1));
      check($sformatf("t2_busy_c%0d", c), busy, 0);
      check($sformatf("t2_mem_en_c%0d", c), mem_en, 0);
      check($sformatf("t2_valid_c%0d", c), m_valid, 0);
    end
    flush();
    next_cycle();

    // Stall pattern 1,0,0,1
    ready_mode = 1; pat_idx = 0;
    drive_ready();
    start_xfer(6'h00, 8);
    wait_done("t3", 200);

    // Address wrap-around
    ready_mode = 0;
    start_xfer(6'h38, 4);
    wait_done("t4", 100);

    // run while busy is ignored
    ready_mode = 1; pat_idx = 0;
    start_xfer(6'h04, 8);
    next_cycle();
    run = 1'b1; start_addr = 6'h30; length = 6'd5;
    next_cycle();
    run = 1'b0;
    next_cycle();
    run = 1'b1;
    next_cycle();
    run = 1'b0;
    wait_done("t6", 200);

    // run during the DONE cycle is ignored
    ready_mode = 0;
    start_xfer(6'h20, 2);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) next_cycle();
      if (c == 4) begin run = 1'b1; start_addr = 6'h00; length = 6'd3; end
      if (c == 5) run = 1'b0;
      @(negedge clk);
      check($sformatf("t6b_done_c%0d", c), done, (c == 4));
      check($sformatf("t6b_busy_c%0d", c), busy, (c <= 3));
      check($sformatf("t6b_mem_en_c%0d", c), mem_en, (c <= 2));
    end
    check("t6b_beats_left", exp_q.size(), 0);
    flush();
    next_cycle();

    // Reset after three of eight beats, then a clean restart
    ready_mode = 0;
    pop_base = n_popped;
    start_xfer(6'h00, 8);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      #1;
      if (n_popped - pop_base >= 3) got = 1;
      else next_cycle();
    end
    check("t5_three_beats", got, 1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    flush();
    @(negedge clk);
    reset_checks("t5_midreset");
    next_cycle();
    rst = 1'b0;
    next_cycle();
    ready_mode = 2;
    start_xfer(6'h14, 6);
    wait_done("t5_restart", 200);

    // Maximum length with random back-pressure
    ready_mode = 2;
    start_xfer(6'($urandom_range(0, 63)), (1 << LEN_W) - 1);
    wait_done("max_len", 1000);

    // Random transfers, unaligned start addresses included
    for (int t = 0; t < 8; t++) begin
      ready_mode = $urandom_range(0, 2);
      pat_idx = 0;
      start_xfer(6'($urandom_range(0, 63)), $urandom_range(1, 20));
      wait_done($sformatf("rand%0d", t), 300);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
